// File: rtl/cic_decim_ctrl.sv
// -----------------------------------------------------------------------------
// cic_decim_ctrl
//
// Sequencing controller for a CIC decimator. The integrator chain runs
// free; this block owns the integrator's synchronous clear, counts input
// samples to produce the decimation strobe for the comb section, and gates
// comb outputs until the comb delay lines hold real data. A run-time ratio
// change re-sequences the filter: FLUSH (clear) -> WARMUP (discard) -> RUN.
//
// Optional feature: define CIC_GAIN_SHIFT_EN to add the gain_shift output
// (STAGES * ceil(log2(ratio_active))) used downstream to normalise R^STAGES.
//
// Ports
//   clk_in        system clock, rising edge
//   rst_n         asynchronous active-low reset
//   din_valid     input sample presented to the integrator this cycle
//   cfg_ratio     new decimation ratio R
//   cfg_load      one-cycle pulse: latch cfg_ratio and restart sequencing
//   int_rst       synchronous clear to the integrator chain (active high)
//   comb_en       decimation strobe to the comb section
//   dout_valid    comb output valid, one cycle after a post-warm-up comb_en
//   busy          high while in FLUSH or WARMUP
//   cfg_err       sticky, set by a cfg_load carrying R < 2
//   ratio_active  ratio currently in use
//   gain_shift    (CIC_GAIN_SHIFT_EN only) gain normalisation shift
//   state_dbg     current FSM state: 0 FLUSH, 1 WARMUP, 2 RUN
//
// Handshake: there is no backpressure anywhere. din_valid and cfg_load are
// qualifiers sampled on every rising edge; comb_en and dout_valid are
// single-cycle strobes that downstream must accept when they are high.
// -----------------------------------------------------------------------------
module cic_decim_ctrl #(
  parameter int          STAGES        = 3,
  parameter int          RATIO_WIDTH   = 16,
  parameter int unsigned DEFAULT_RATIO = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   din_valid,
  input  logic [RATIO_WIDTH-1:0] cfg_ratio,
  input  logic                   cfg_load,
  output logic                   int_rst,
  output logic                   comb_en,
  output logic                   dout_valid,
  output logic                   busy,
  output logic                   cfg_err,
  output logic [RATIO_WIDTH-1:0] ratio_active,
`ifdef CIC_GAIN_SHIFT_EN
  output logic [7:0]             gain_shift,
`endif
  output logic [1:0]             state_dbg
);

  localparam logic [RATIO_WIDTH-1:0] DEF_R = RATIO_WIDTH'(DEFAULT_RATIO);
  localparam int CNT_W = (STAGES < 1) ? 1 : $clog2(STAGES + 1);

  typedef enum logic [1:0] {
    S_FLUSH  = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       flush_q, flush_d;
  logic [CNT_W-1:0]       warm_q, warm_d;
  logic [RATIO_WIDTH-1:0] dec_q, dec_d;
  logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
  logic                   err_q, err_d;
  logic                   comb_q, comb_d;
  // fire_q marks a strobe issued in RUN; it becomes dout_valid one cycle
  // later unless a ratio reload kills it first.
  logic                   fire_q, fire_d;
  logic                   dv_q, dv_d;
  logic                   int_rst_q;
  logic                   busy_q;

  logic                   load_ok;
  logic                   load_bad;
  logic                   terminal;

  assign load_ok  = cfg_load && (cfg_ratio >= RATIO_WIDTH'(2));
  assign load_bad = cfg_load && !load_ok;
  assign terminal = din_valid && (dec_q == (ratio_q - RATIO_WIDTH'(1)));

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    warm_d  = warm_q;
    dec_d   = dec_q;
    ratio_d = ratio_q;
    err_d   = err_q;
    comb_d  = 1'b0;
    fire_d  = 1'b0;
    dv_d    = fire_q;

    if (load_ok) begin
      // A valid reload overrides everything, including a coincident strobe.
      ratio_d = cfg_ratio;
      err_d   = 1'b0;
      state_d = S_FLUSH;
      flush_d = '0;
      warm_d  = '0;
      dec_d   = '0;
      dv_d    = 1'b0;
    end else begin
      if (load_bad) begin
        err_d = 1'b1;
      end
      unique case (state_q)
        S_FLUSH: begin
          if (flush_q == CNT_W'(STAGES)) begin
            state_d = S_WARMUP;
            flush_d = '0;
          end else begin
            flush_d = flush_q + CNT_W'(1);
          end
        end
        S_WARMUP: begin
          if (terminal) begin
            dec_d  = '0;
            comb_d = 1'b1;
            if (warm_q == CNT_W'(STAGES - 1)) begin
              state_d = S_RUN;
              warm_d  = '0;
            end else begin
              warm_d = warm_q + CNT_W'(1);
            end
          end else if (din_valid) begin
            dec_d = dec_q + RATIO_WIDTH'(1);
          end
        end
        S_RUN: begin
          if (terminal) begin
            dec_d  = '0;
            comb_d = 1'b1;
            fire_d = 1'b1;
          end else if (din_valid) begin
            dec_d = dec_q + RATIO_WIDTH'(1);
          end
        end
        default: begin
          state_d = S_FLUSH;
          flush_d = '0;
          warm_d  = '0;
          dec_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FLUSH;
      flush_q   <= '0;
      warm_q    <= '0;
      dec_q     <= '0;
      ratio_q   <= DEF_R;
      err_q     <= 1'b0;
      comb_q    <= 1'b0;
      fire_q    <= 1'b0;
      dv_q      <= 1'b0;
      int_rst_q <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      warm_q    <= warm_d;
      dec_q     <= dec_d;
      ratio_q   <= ratio_d;
      err_q     <= err_d;
      comb_q    <= comb_d;
      fire_q    <= fire_d;
      dv_q      <= dv_d;
      // Registered from next-state so these flags line up with state_q.
      int_rst_q <= (state_d == S_FLUSH);
      busy_q    <= (state_d != S_RUN);
    end
  end

  assign int_rst      = int_rst_q;
  assign comb_en      = comb_q;
  assign dout_valid   = dv_q;
  assign busy         = busy_q;
  assign cfg_err      = err_q;
  assign ratio_active = ratio_q;
  assign state_dbg    = state_q;

`ifdef CIC_GAIN_SHIFT_EN
  // ceil(log2(r)) = index of the top set bit, plus one unless r is a power
  // of two. r is always >= 2 here.
  function automatic logic [7:0] calc_gain(input logic [RATIO_WIDTH-1:0] r);
    int   msb;
    int   cl;
    logic pow2;
    msb = 0;
    for (int i = 0; i < RATIO_WIDTH; i++) begin
      if (r[i]) msb = i;
    end
    pow2 = ((r & (r - RATIO_WIDTH'(1))) == '0);
    cl   = pow2 ? msb : msb + 1;
    return 8'(STAGES * cl);
  endfunction

  logic [7:0] gain_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      gain_q <= calc_gain(DEF_R);
    end else begin
      gain_q <= calc_gain(ratio_q);
    end
  end

  assign gain_shift = gain_q;
`endif

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cic_decim_ctrl
//
// Self-checking bench for cic_decim_ctrl (STAGES=3, RATIO_WIDTH=16, R0=8).
// A behavioural model tracks the filter in terms of "cycles spent clearing",
// "valid samples since warm-up began" and "strobes since restart"; every
// falling edge the DUT outputs are compared with it. Directed phases pin the
// model with hand-derived literal timings, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_cic_decim_ctrl;

  localparam int STAGES = 3;
  localparam int RW     = 16;
  localparam int DEF_R  = 8;

  // ---------------- clock / reset ----------------
  logic          clk_in     = 1'b0;
  logic          rst_n      = 1'b0;
  logic          din_valid  = 1'b0;
  logic [RW-1:0] cfg_ratio  = '0;
  logic          cfg_load   = 1'b0;
  logic          int_rst;
  logic          comb_en;
  logic          dout_valid;
  logic          busy;
  logic          cfg_err;
  logic [RW-1:0] ratio_active;
  logic [1:0]    state_dbg;
`ifdef CIC_GAIN_SHIFT_EN
  logic [7:0]    gain_shift;
`endif

  always #5 clk_in = ~clk_in;

  cic_decim_ctrl #(
    .STAGES(STAGES),
    .RATIO_WIDTH(RW),
    .DEFAULT_RATIO(DEF_R)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .din_valid(din_valid),
    .cfg_ratio(cfg_ratio),
    .cfg_load(cfg_load),
    .int_rst(int_rst),
    .comb_en(comb_en),
    .dout_valid(dout_valid),
    .busy(busy),
    .cfg_err(cfg_err),
    .ratio_active(ratio_active),
`ifdef CIC_GAIN_SHIFT_EN
    .gain_shift(gain_shift),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_ratio;
  int            m_fl;       // clearing cycles completed since restart
  int            m_vcnt;     // valid samples since warm-up began
  int            m_strobes;  // strobes since restart
  bit            m_err;
  bit            m_pend;     // a post-warm-up strobe awaiting its dout_valid
  bit            e_int_rst, e_comb, e_dv, e_busy, e_err;
  int            e_ratio;
  int            e_gs;
  logic [RW-1:0] exp_q[$];   // ratio expected alongside each dout_valid

  function automatic int gain_of(input int r);
    int c = 0;
    while ((1 << c) < r) c++;
    return STAGES * c;
  endfunction

  task automatic model_reset();
    m_ratio = DEF_R; m_fl = 0; m_vcnt = 0; m_strobes = 0;
    m_err = 0; m_pend = 0;
    e_int_rst = 1; e_comb = 0; e_dv = 0; e_busy = 1; e_err = 0;
    e_ratio = DEF_R; e_gs = gain_of(DEF_R);
    exp_q.delete();
  endtask

  task automatic model_step();
    e_gs = gain_of(m_ratio);
    if (cfg_load && cfg_ratio >= 2) begin
      m_ratio = int'(cfg_ratio); m_err = 0;
      m_fl = 0; m_vcnt = 0; m_strobes = 0; m_pend = 0;
      e_comb = 0; e_dv = 0;
    end else begin
      if (cfg_load) m_err = 1;
      e_dv = m_pend;
      if (e_dv) exp_q.push_back(RW'(m_ratio));
      m_pend = 0;
      e_comb = 0;
      if (m_fl < STAGES + 1) begin
        m_fl++;
      end else if (din_valid) begin
        m_vcnt++;
        if (m_vcnt % m_ratio == 0) begin
          m_strobes++;
          e_comb = 1;
          m_pend = (m_strobes > STAGES);
        end
      end
    end
    e_int_rst = (m_fl < STAGES + 1);
    e_busy    = (m_fl < STAGES + 1) || (m_strobes < STAGES);
    e_err     = m_err;
    e_ratio   = m_ratio;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_in or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- compare process (scoreboard) ----------------
  initial begin
    logic [RW-1:0] v;
    forever begin
      @(negedge clk_in);
      check("int_rst", int_rst, e_int_rst);
      check("comb_en", comb_en, e_comb);
      check("dout_valid", dout_valid, e_dv);
      check("busy", busy, e_busy);
      check("cfg_err", cfg_err, e_err);
      check("ratio_active", ratio_active, e_ratio);
`ifdef CIC_GAIN_SHIFT_EN
      check("gain_shift", gain_shift, e_gs);
`endif
      if (e_dv && exp_q.size() > 0) begin
        v = exp_q.pop_front();
        check("dv_ratio", ratio_active, v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_load(input int r);
    @(negedge clk_in);
    cfg_ratio = RW'(r);
    cfg_load  = 1'b1;
    @(negedge clk_in);
    cfg_load  = 1'b0;
  endtask

  task automatic wait_run(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check("wait_run_timeout", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int first_comb, first_dv, busy_fall, n_int, n_comb, last, found;

    repeat (3) @(negedge clk_in);
    check("rst_ratio", ratio_active, DEF_R);
    check("rst_int_rst", int_rst, 1);
    check("rst_busy", busy, 1);

    // Reset release, din_valid constant 1, R=8.
    @(posedge clk_in); #1 rst_n = 1'b1; din_valid = 1'b1;
    first_comb = -1; first_dv = -1; busy_fall = -1; n_int = 0; n_comb = 0;
    for (int s = 0; s <= 40; s++) begin
      @(negedge clk_in);
      if (int_rst) n_int++;
      if (comb_en) n_comb++;
      if (comb_en && first_comb < 0) first_comb = s;
      if (dout_valid && first_dv < 0) first_dv = s;
      if (!busy && busy_fall < 0) busy_fall = s;
    end
    check("flush_cycles", n_int, 4);
    check("first_comb", first_comb, 12);
    check("comb_count_r8", n_comb, 4);
    check("busy_fall", busy_fall, 28);
    check("first_dv", first_dv, 37);

    // R=4, din_valid toggling in RUN: strobe every 8 clocks.
    pulse_load(4);
    wait_run(300);
    last = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_in);
      if (comb_en) begin
        if (last >= 0) check("toggle_period", i - last, 8);
        last = i;
      end
      din_valid = ~din_valid;
    end
    din_valid = 1'b1;

    // Reload R=5 mid-RUN.
    pulse_load(5);
    check("load5_busy", busy, 1);
    check("load5_ratio", ratio_active, 5);
    n_int = 0; n_comb = 0; first_dv = -1; last = -1;
    for (int i = 0; i < 60; i++) begin
      if (int_rst) n_int++;
`ifdef CIC_GAIN_SHIFT_EN
      if (i == 2) check("gain_r5", gain_shift, 9);
`endif
      if (dout_valid) begin
        if (last >= 0) check("r5_dv_period", i - last, 5);
        else first_dv = i;
        last = i;
      end
      if (comb_en && first_dv < 0) n_comb++;
      @(negedge clk_in);
    end
    check("load5_flush_cycles", n_int, 4);
    check("load5_strobes_before_dv", n_comb, 4);

    // Bad ratio: sticky error, nothing else changes; a good load clears it.
    pulse_load(1);
    check("bad_cfg_err", cfg_err, 1);
    check("bad_ratio_kept", ratio_active, 5);
    check("bad_busy", busy, 0);
    repeat (12) @(negedge clk_in);
    pulse_load(6);
    check("good_cfg_err", cfg_err, 0);
    check("good_ratio", ratio_active, 6);
    wait_run(300);

    // Reload coincident with a terminal-count sample.
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk_in);
      if (m_fl >= STAGES + 1 && (m_vcnt % m_ratio) == m_ratio - 1) found = 1;
    end
    check("coincident_found", found, 1);
    cfg_ratio = RW'(7);
    cfg_load  = 1'b1;
    @(negedge clk_in);
    cfg_load  = 1'b0;
    check("coincident_comb", comb_en, 0);
    check("coincident_flush", int_rst, 1);

    // Reset during WARMUP, with cfg_err set beforehand.
    for (int i = 0; i < 20 && int_rst; i++) @(negedge clk_in);
    check("warmup_reached", int_rst, 0);
    pulse_load(0);
    check("pre_rst_err", cfg_err, 1);
    @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check("async_int_rst", int_rst, 1);
    check("async_comb", comb_en, 0);
    check("async_dv", dout_valid, 0);
    check("async_busy", busy, 1);
    check("async_err", cfg_err, 0);
    check("async_ratio", ratio_active, DEF_R);
`ifdef CIC_GAIN_SHIFT_EN
    check("async_gain", gain_shift, 9);
`endif
    repeat (2) @(negedge clk_in);
    @(posedge clk_in); #1 rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      din_valid = ($urandom_range(0, 99) < 70);
      cfg_load  = ($urandom_range(0, 199) == 0);
      cfg_ratio = RW'($urandom_range(0, 12));
    end
    @(negedge clk_in);
    cfg_load = 1'b0;
    repeat (5) @(negedge clk_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
